// File: rtl/mc_core_param.sv
// mc_core_param: parameterised multi-cycle core with an integrated control FSM,
// a stalling req/ready port to one unified instruction/data memory, halt and
// illegal-opcode handling, a retire strobe and a debug register read port.
// The branch target is staged in ALUOut, so AW is expected to be <= DW.
module mc_core_param #(
    parameter int DW  = 16,
    parameter int AW  = 10,
    parameter int RAW = 3
) (
    input  logic           clock,
    input  logic           reset,
    output logic           mem_req,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata,
    input  logic           mem_ready,
    output logic           retire,
    output logic           halted,
    output logic           illegal,
    output logic [AW-1:0]  pc_out,
    input  logic [RAW-1:0] dbg_raddr,
    output logic [DW-1:0]  dbg_rdata
);

    localparam int NREG = 1 << RAW;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_SW   = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_J    = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_ILL  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   alu_out_q, alu_out_d;
    logic [DW-1:0]   mdr_q, mdr_d;
    logic            illegal_q, illegal_d;
    logic [DW-1:0]   regs_q [NREG];

    logic            rf_we;
    logic [RAW-1:0]  rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            req_c, we_c, retire_c;
    logic [AW-1:0]   addr_c;
    logic [DW-1:0]   alu_res;

    // Instruction fields; only the low RAW bits of each register field matter
    logic [2:0]        op;
    logic [RAW-1:0]    rs_idx, rt_idx, rd_idx;
    logic [3:0]        funct;
    logic signed [6:0] imm7;
    logic [DW-1:0]     imm_dw;
    logic [AW-1:0]     imm_aw;

    assign op     = ir_q[15:13];
    assign rs_idx = ir_q[10 +: RAW];
    assign rt_idx = ir_q[7 +: RAW];
    assign rd_idx = ir_q[4 +: RAW];
    assign funct  = ir_q[3:0];
    assign imm7   = ir_q[6:0];
    assign imm_dw = DW'(imm7);
    assign imm_aw = AW'(imm7);

    // ALU result for R-type (by funct) and ADDI; unknown functs produce 0
    always_comb begin
        alu_res = '0;
        if (op == OP_ADDI) begin
            alu_res = a_q + imm_dw;
        end else begin
            case (funct)
                4'd0:    alu_res = a_q + b_q;
                4'd1:    alu_res = a_q - b_q;
                4'd2:    alu_res = a_q & b_q;
                4'd3:    alu_res = a_q | b_q;
                4'd4:    alu_res = DW'($signed(a_q) < $signed(b_q));
                default: alu_res = '0;
            endcase
        end
    end

    // Control FSM: next state, datapath register updates and memory port drive
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_waddr  = rd_idx;
        rf_wdata  = alu_out_q;
        req_c     = 1'b0;
        we_c      = 1'b0;
        addr_c    = pc_q;
        retire_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c  = 1'b1;
                addr_c = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata[15:0];
                    pc_d    = pc_q + AW'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d       = regs_q[rs_idx];
                b_d       = regs_q[rt_idx];
                // pc_q already points past this instruction
                alu_out_d = DW'(pc_q + imm_aw);
                case (op)
                    OP_J: begin
                        pc_d     = AW'(ir_q[12:0]);
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_ILL: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (op)
                    OP_BEQ: begin
                        if (a_q == b_q) begin
                            pc_d = AW'(alu_out_q);
                        end
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_LW, OP_SW: begin
                        alu_out_d = a_q + imm_dw;
                        state_d   = S_MEM;
                    end
                    default: begin
                        alu_out_d = alu_res;
                        state_d   = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                req_c  = 1'b1;
                addr_c = AW'(alu_out_q);
                we_c   = (op == OP_SW);
                if (mem_ready) begin
                    if (op == OP_SW) begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (op == OP_R) ? rd_idx : rt_idx;
                rf_wdata = (op == OP_LW) ? mdr_q : alu_out_q;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
        end
    end

    // Register file; r0 is never written so it always reads 0
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we && (rf_waddr != '0)) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Strobes are suppressed during reset so an in-flight request is abandoned
    assign mem_req   = req_c & ~reset;
    assign mem_we    = we_c & req_c & ~reset;
    assign retire    = retire_c & ~reset;
    assign mem_addr  = addr_c;
    assign mem_wdata = b_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign pc_out    = pc_q;
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs_q[dbg_raddr];

endmodule
